// File: rtl/seq_divider.sv
// Sequential restoring divider: NW-bit dividend by DW-bit divisor, one quotient bit per cycle.
// Handshake: start is taken whenever not busy; done pulses one cycle with the result held until the next take.
module seq_divider #(
    parameter int NW = 10,
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          div_zero,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CW = $clog2(NW);
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    state_e        state_q;
    logic [NW-1:0] dvd_q;
    logic [DW-1:0] dsr_q;
    logic [DW:0]   r_q;
    logic [DW:0]   r_d;
    logic [DW:0]   r_shift;
    logic [NW-1:0] quot_q;
    logic [NW-1:0] quot_d;
    logic [CW-1:0] cnt_q;
    logic          qbit;
    logic          accept;

    logic          busy_q;
    logic          done_q;
    logic          div_zero_q;
    logic [NW-1:0] quotient_q;
    logic [DW-1:0] remainder_q;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        accept  = start && (state_q != CALC);
        r_shift = {r_q[DW-1:0], dvd_q[NW-1]};
        r_d     = r_shift;
        qbit    = 1'b0;
        if (r_shift >= {1'b0, dsr_q}) begin
            r_d  = r_shift - {1'b0, dsr_q};
            qbit = 1'b1;
        end
        quot_d = {quot_q[NW-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            r_q         <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CALC: begin
                    r_q    <= r_d;
                    quot_q <= quot_d;
                    dvd_q  <= {dvd_q[NW-2:0], 1'b0};
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= quot_d;
                        remainder_q <= r_d[DW-1:0];
                    end
                end
                default: begin
                    if (accept) begin
                        dvd_q      <= dividend;
                        dsr_q      <= divisor;
                        r_q        <= '0;
                        quot_q     <= '0;
                        cnt_q      <= '0;
                        div_zero_q <= (divisor == '0);
                        // A zero divisor skips iteration and reports a saturated quotient.
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end else if (state_q == DONE) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner runs plus randomized divisions
// compared against an arithmetic model through an expected-result queue.
module tb_seq_divider;
  localparam int NW = 10;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] dividend = '0;
  logic [DW-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  seq_divider #(.NW(NW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero), .quotient(quotient),
    .remainder(remainder), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference: plain integer division, packed as {div_zero, quotient, remainder}
  function automatic logic [15:0] model(input int a, input int b);
    if (b == 0) return {1'b1, 10'h3FF, 5'd0};
    return {1'b0, 10'(a / b), 5'(a % b)};
  endfunction

  // driver: called on a falling edge; the next rising edge accepts
  task automatic launch(input logic [NW-1:0] a, input logic [DW-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(model(int'(a), int'(b)));
  endtask

  // waits for done after a launch; glitch >= 0 pulses start with foreign operands mid-run;
  // chain re-launches during the done cycle.
  task automatic collect(input string tag, input int glitch, input bit chain,
                         input logic [NW-1:0] na, input logic [DW-1:0] nb);
    int n;
    bit seen;
    logic [15:0] e;
    n = 0;
    seen = 1'b0;
    e = exp_q[0];
    @(posedge clk);
    while (!seen && n < 40) begin
      @(negedge clk);
      if (n == 0) check($sformatf("%s_busy_first", tag), busy, !e[15]);
      if (done) begin
        seen = 1'b1;
      end else begin
        start = (n == glitch);
        if (n == glitch) begin
          dividend = 10'd55;
          divisor  = 5'd3;
        end
        @(posedge clk);
        n++;
      end
    end
    check($sformatf("%s_done_seen", tag), seen, 1);
    e = exp_q.pop_front();
    if (seen) begin
      check($sformatf("%s_latency", tag), n, e[15] ? 0 : NW);
      check($sformatf("%s_busy_done", tag), busy, 0);
      check($sformatf("%s_quotient", tag), quotient, e[14:5]);
      check($sformatf("%s_remainder", tag), remainder, e[4:0]);
      check($sformatf("%s_div_zero", tag), div_zero, e[15]);
    end
    if (chain) begin
      launch(na, nb);
    end else begin
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_done_pulse", tag), done, 0);
    end
  endtask

  initial begin
    logic [NW-1:0] a;
    logic [DW-1:0] b;
    bit chain;
    int dcount;

    // reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed
    launch(10'd1000, 5'd7);  collect("d1000_7", -1, 1'b0, '0, '0);
    launch(10'd1023, 5'd31); collect("d1023_31", -1, 1'b0, '0, '0);
    launch(10'd5, 5'd9);     collect("d5_9", -1, 1'b0, '0, '0);
    launch(10'd391, 5'd0);   collect("d391_0", -1, 1'b0, '0, '0);
    launch(10'd391, 5'd17);  collect("glitch", 3, 1'b0, '0, '0);

    // back-to-back, including a zero divisor inside the chain
    launch(10'd700, 5'd13);  collect("b2b_a", -1, 1'b1, 10'd9, 5'd0);
    collect("b2b_b", -1, 1'b1, 10'd1023, 5'd1);
    collect("b2b_c", -1, 1'b0, '0, '0);

    // reset in the middle of a run
    launch(10'd200, 5'd9);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_div_zero", div_zero, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("mid_rst_no_done", dcount, 0);
    launch(10'd100, 5'd3);   collect("after_rst", -1, 1'b0, '0, '0);

    // randomized sweep with boundary-biased operands and random chaining
    a = 10'($urandom_range(0, 1023));
    b = 5'($urandom_range(0, 31));
    launch(a, b);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: a = 10'd0;
        1: a = 10'd1023;
        default: a = 10'($urandom_range(0, 1023));
      endcase
      case ($urandom_range(0, 9))
        0: b = 5'd0;
        1: b = 5'd1;
        2: b = 5'd31;
        default: b = 5'($urandom_range(1, 31));
      endcase
      chain = ($urandom_range(0, 1) == 1);
      collect("rnd", -1, chain, a, b);
      if (!chain) launch(a, b);
    end
    collect("rnd_last", -1, 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
